// File: rtl/crc32_pkg.sv
// Shared constants and state encoding for the CRC-32 frame sequencer.
// The CRC is the reflected IEEE 802.3 variant.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

   // Controller phases: waiting to start, reading the header word,
   // folding payload words, and holding the finished CRC for the consumer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } ctrlState_t;

endpackage

// File: rtl/crc32_word_step.sv
// Combinational single-word CRC-32 update. Folds a whole 32-bit word into
// the running CRC in one pass. It is kept free of controller details so
// that other CRC blocks can reuse it.
module crc32_word_step
   import crc32_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [31:0] data,
   output logic [31:0] next_crc
);

   logic [31:0] crcWork;

   // Bytes go in from byte 0 upward, and bits go in LSB first within each
   // byte. That order is simply data[0] through data[31]. Each step is one
   // shift of the reflected LFSR. The polynomial is XORed in whenever the
   // bit shifted out differs from the incoming data bit.
   always_comb begin
      crcWork = crc_in;
      for (int i = 0; i < 32; i++) begin
         if (crcWork[0] ^ data[i]) begin
            crcWork = (crcWork >> 1) ^ CRC32_POLY;
         end else begin
            crcWork = crcWork >> 1;
         end
      end
      next_crc = crcWork;
   end

endmodule

// File: rtl/crc32_fifo_ctrl.sv
// Frame sequencer. It pops a length header from a show-ahead FIFO, then
// that many payload words, and folds each payload word into a CRC-32.
// The finished CRC is offered on a valid/ready pair, and each accepted
// frame is counted.
module crc32_fifo_ctrl
   import crc32_pkg::*;
#(
   parameter int LEN_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [31:0]      fifo_rdata,
   output logic             fifo_ren,
   output logic             crc_valid,
   input  logic             crc_ready,
   output logic [31:0]      crc_data,
   output logic [LEN_W-1:0] crc_len,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   ctrlState_t       state;
   ctrlState_t       nextState;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      crcReg;
   logic [31:0]      crcNext;
   logic [LEN_W-1:0] lengthField;

   assign lengthField = fifo_rdata[LEN_W-1:0];

   crc32_word_step u_step (
      .crc_in   (crcReg),
      .data     (fifo_rdata),
      .next_crc (crcNext)
   );

   // The state register. Reset drops straight back to IDLE so that a
   // partial frame is thrown away together with the FIFO contents.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and pop decode. A pop happens only while the FIFO has a
   // word and we are reading a header or payload. The popped word is
   // consumed on the same edge, so there is never an outstanding read.
   always_comb begin
      nextState = state;
      fifo_ren  = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               nextState = HDR;
            end
         end
         HDR: begin
            if (!fifo_empty) begin
               fifo_ren  = 1'b1;
               nextState = (lengthField == '0) ? DONE : DATA;
            end
         end
         DATA: begin
            if (!fifo_empty) begin
               fifo_ren = 1'b1;
               if (remaining == LEN_W'(1)) begin
                  nextState = DONE;
               end
            end
         end
         DONE: begin
            if (crc_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Frame datapath. The header loads the length and restarts the CRC.
   // Each payload pop folds in one word. The final pop publishes the
   // complemented CRC, and crc_data/crc_len then stay put until the next
   // frame overwrites them. An empty frame publishes zero straight away.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         remaining <= '0;
         crcReg    <= CRC32_INIT;
         crc_data  <= '0;
         crc_len   <= '0;
      end else begin
         if (state == HDR && !fifo_empty) begin
            crc_len   <= lengthField;
            remaining <= lengthField;
            crcReg    <= CRC32_INIT;
            if (lengthField == '0) begin
               crc_data <= '0;
            end
         end else if (state == DATA && !fifo_empty) begin
            crcReg    <= crcNext;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
               crc_data <= crcNext ^ CRC32_XOROUT;
            end
         end
      end
   end

   // Count a frame only when the consumer actually takes the CRC. A ready
   // seen outside DONE has no effect. The counter wraps freely.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (state == DONE && crc_ready) begin
         frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end

   assign crc_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_crc32_fifo_ctrl.sv
// Directed bench for crc32_fifo_ctrl. A small show-ahead FIFO model feeds
// the controller. The frame counter is narrowed to two bits so that it
// wraps within a handful of frames.
module tb_crc32_fifo_ctrl;

   localparam int TB_LEN_W = 16;
   localparam int TB_CNT_W = 2;

   logic                clock;
   logic                reset;
   logic                enable;
   logic                fifo_empty;
   logic [31:0]         fifo_rdata;
   logic                fifo_ren;
   logic                crc_valid;
   logic                crc_ready;
   logic [31:0]         crc_data;
   logic [TB_LEN_W-1:0] crc_len;
   logic                busy;
   logic [TB_CNT_W-1:0] frame_cnt;

   logic [31:0] fifoMem [0:63];
   logic [5:0]  wrPtr;
   logic [5:0]  rdPtr;
   int          cycleCount;
   int          renWhileEmpty;
   int          popLog[$];

   int checks;
   int failures;
   int popBase;

   crc32_fifo_ctrl #(
      .LEN_W (TB_LEN_W),
      .CNT_W (TB_CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_ren   (fifo_ren),
      .crc_valid  (crc_valid),
      .crc_ready  (crc_ready),
      .crc_data   (crc_data),
      .crc_len    (crc_len),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Show-ahead FIFO model. The read pointer shares the controller's reset.
   assign fifo_empty = (rdPtr == wrPtr);
   assign fifo_rdata = fifoMem[rdPtr];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr <= '0;
      end else if (fifo_ren) begin
         rdPtr <= rdPtr + 6'd1;
      end
   end

   // Pop log with cycle stamps, plus a record of any pop issued while empty.
   always @(posedge clock) begin
      cycleCount <= cycleCount + 1;
      if (fifo_ren) begin
         popLog.push_back(cycleCount);
         if (fifo_empty) begin
            renWhileEmpty <= renWhileEmpty + 1;
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] word);
      fifoMem[wrPtr] = word;
      wrPtr = wrPtr + 6'd1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic waitValid(input string tag);
      int guard;
      guard = 0;
      while (!crc_valid && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      checkOutput({tag, "_valid"}, {31'b0, crc_valid}, 32'd1);
   endtask

   task automatic waitPops(input string tag, input int target);
      int guard;
      guard = 0;
      while (popLog.size() < target && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      checkOutput(tag, popLog.size(), target);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      cycleCount    = 0;
      renWhileEmpty = 0;
      wrPtr         = '0;
      reset         = 1'b1;
      enable        = 1'b0;
      crc_ready     = 1'b0;
      for (int i = 0; i < 64; i++) fifoMem[i] = '0;

      // Values held during reset
      repeat (2) @(negedge clock);
      checkOutput("rst_fifo_ren", {31'b0, fifo_ren}, 32'd0);
      checkOutput("rst_crc_valid", {31'b0, crc_valid}, 32'd0);
      checkOutput("rst_crc_data", crc_data, 32'h0);
      checkOutput("rst_crc_len", {16'b0, crc_len}, 32'h0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_frame_cnt", {30'b0, frame_cnt}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Single word "1234"
      popBase = popLog.size();
      applyStimulus(32'h00000001);
      applyStimulus(32'h34333231);
      crc_ready = 1'b1;
      enable    = 1'b1;
      waitValid("t1");
      checkOutput("t1_crc_data", crc_data, 32'h9BE3E0A3);
      checkOutput("t1_crc_len", {16'b0, crc_len}, 32'd1);
      @(negedge clock);
      checkOutput("t1_frame_cnt", {30'b0, frame_cnt}, 32'd1);
      checkOutput("t1_valid_low", {31'b0, crc_valid}, 32'd0);
      checkOutput("t1_pops", popLog.size() - popBase, 32'd2);

      // Two words with a starved FIFO between them
      popBase = popLog.size();
      applyStimulus(32'h00000002);
      applyStimulus(32'h34333231);
      waitPops("t2_first_pops", popBase + 2);
      for (int i = 0; i < 5; i++) begin
         checkOutput("t2_starve_ren", {31'b0, fifo_ren}, 32'd0);
         @(negedge clock);
      end
      checkOutput("t2_starve_busy", {31'b0, busy}, 32'd1);
      applyStimulus(32'h38373635);
      waitValid("t2");
      checkOutput("t2_crc_data", crc_data, 32'h9AE0DAAF);
      checkOutput("t2_crc_len", {16'b0, crc_len}, 32'd2);
      @(negedge clock);
      checkOutput("t2_frame_cnt", {30'b0, frame_cnt}, 32'd2);

      // Zero-length frame held back by the consumer
      crc_ready = 1'b0;
      popBase   = popLog.size();
      applyStimulus(32'h00000000);
      waitValid("t3");
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("t3_hold_valid", {31'b0, crc_valid}, 32'd1);
         checkOutput("t3_hold_data", crc_data, 32'h0);
      end
      checkOutput("t3_crc_len", {16'b0, crc_len}, 32'd0);
      checkOutput("t3_pops", popLog.size() - popBase, 32'd1);
      checkOutput("t3_cnt_before", {30'b0, frame_cnt}, 32'd2);
      crc_ready = 1'b1;
      @(negedge clock);
      checkOutput("t3_frame_cnt", {30'b0, frame_cnt}, 32'd3);
      checkOutput("t3_valid_low", {31'b0, crc_valid}, 32'd0);

      // Back-to-back frames. The counter wraps through zero.
      popBase = popLog.size();
      applyStimulus(32'h00000001);
      applyStimulus(32'h00000000);
      applyStimulus(32'h00000001);
      applyStimulus(32'hFFFFFFFF);
      waitValid("t4a");
      checkOutput("t4a_crc_data", crc_data, 32'h2144DF1C);
      @(negedge clock);
      checkOutput("t4a_frame_cnt_wrap", {30'b0, frame_cnt}, 32'd0);
      waitValid("t4b");
      checkOutput("t4b_crc_data", crc_data, 32'hFFFFFFFF);
      @(negedge clock);
      checkOutput("t4b_frame_cnt", {30'b0, frame_cnt}, 32'd1);
      checkOutput("t4_pops", popLog.size() - popBase, 32'd4);
      if (popLog.size() >= popBase + 3) begin
         checkOutput("t4_turnaround", popLog[popBase + 2] - popLog[popBase + 1], 32'd3);
      end else begin
         checkOutput("t4_turnaround_pops", popLog.size(), popBase + 3);
      end

      // Reset in the middle of a frame, with the FIFO cleared alongside
      popBase = popLog.size();
      applyStimulus(32'h00000003);
      applyStimulus(32'h11111111);
      waitPops("t5_pops", popBase + 2);
      checkOutput("t5_busy_mid", {31'b0, busy}, 32'd1);
      checkOutput("t5_len_mid", {16'b0, crc_len}, 32'd3);
      #2;
      reset = 1'b1;
      wrPtr = '0;
      #1;
      checkOutput("t5_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("t5_rst_crc_data", crc_data, 32'h0);
      checkOutput("t5_rst_crc_len", {16'b0, crc_len}, 32'h0);
      checkOutput("t5_rst_frame_cnt", {30'b0, frame_cnt}, 32'd0);
      checkOutput("t5_rst_valid", {31'b0, crc_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(32'h00000001);
      applyStimulus(32'h34333231);
      waitValid("t5");
      checkOutput("t5_crc_data", crc_data, 32'h9BE3E0A3);
      @(negedge clock);
      checkOutput("t5_frame_cnt", {30'b0, frame_cnt}, 32'd1);

      // Only the low bits of the header carry the length
      applyStimulus(32'hABCD0001);
      applyStimulus(32'h34333231);
      waitValid("t6");
      checkOutput("t6_crc_len", {16'b0, crc_len}, 32'h0001);
      checkOutput("t6_crc_data", crc_data, 32'h9BE3E0A3);
      @(negedge clock);
      checkOutput("t6_frame_cnt", {30'b0, frame_cnt}, 32'd2);

      checkOutput("ren_while_empty", renWhileEmpty, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
